// File: rtl/cruise_pkg.sv
// Shared constants, state encoding and per-cycle action codes for the cruise controller.
package cruise_pkg;

  localparam int SPEED_W = 8;

  localparam logic [SPEED_W-1:0] MIN_CRUISE_DEF = 8'd45;
  localparam logic [SPEED_W-1:0] BRAKE_STEP_DEF = 8'd2;
  localparam logic [SPEED_W-1:0] SPEED_ONE      = 8'd1;
  localparam logic [SPEED_W-1:0] SPEED_ZERO     = 8'd0;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_CRUISE = 2'd1,
    ST_ACCEL  = 2'd2,
    ST_COAST  = 2'd3
  } state_e;

  // What the controller does with speed/target in a given cycle, after input priority is resolved.
  typedef enum logic [3:0] {
    ACT_DROP     = 4'd0,  // -1, end in MANUAL (coast-down or cancel)
    ACT_RISE     = 4'd1,  // +1, end in MANUAL (throttle)
    ACT_BRAKE    = 4'd2,  // -BRAKE_STEP, end in MANUAL
    ACT_SET      = 4'd3,  // capture current speed as target, hold speed
    ACT_RESUME   = 4'd4,  // re-engage stored target, step toward it
    ACT_OVERRIDE = 4'd5,  // throttle override while cruising
    ACT_TRACK    = 4'd6,  // step 1 toward target
    ACT_ACCEL    = 4'd7,  // +1, target follows speed
    ACT_COAST    = 4'd8   // -1, target follows speed
  } action_e;

endpackage

// File: rtl/speed_alu.sv
// Saturating 8-bit add/subtract used for every speed update.
module speed_alu
  import cruise_pkg::*;
(
  input  logic [SPEED_W-1:0] operand_i,
  input  logic [SPEED_W-1:0] step_i,
  input  logic               sub_i,
  output logic [SPEED_W-1:0] result_o,
  output logic               flag_o
);

  logic [SPEED_W:0] raw_s;

  // Widen by one bit so the top bit is the carry (add) or borrow (sub), then clamp on it.
  always_comb begin
    if (sub_i) begin
      raw_s = {1'b0, operand_i} - {1'b0, step_i};
    end else begin
      raw_s = {1'b0, operand_i} + {1'b0, step_i};
    end
    flag_o = raw_s[SPEED_W];
    if (flag_o) begin
      result_o = sub_i ? {SPEED_W{1'b0}} : {SPEED_W{1'b1}};
    end else begin
      result_o = raw_s[SPEED_W-1:0];
    end
  end

endmodule

// File: rtl/cruise_speed_ctrl.sv
// Cruise control FSM: tracks vehicle speed, stores a target and steers toward it.
module cruise_speed_ctrl
  import cruise_pkg::*;
#(
  parameter logic [SPEED_W-1:0] MIN_CRUISE = MIN_CRUISE_DEF,
  parameter logic [SPEED_W-1:0] BRAKE_STEP = BRAKE_STEP_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               throttle,
  input  logic               brake,
  input  logic               set,
  input  logic               resume,
  input  logic               cancel,
  input  logic               accel,
  input  logic               coast,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] cruise_speed,
  output logic               cruise_active,
  output logic [1:0]         state
);

  state_e             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, cruise_q, cruise_d;
  logic               valid_q, valid_d;
  logic               active_q;

  action_e            act_s;
  logic [SPEED_W-1:0] alu_step_s, alu_res_s;
  logic               alu_sub_s, alu_flag_s;

  // Resolve input priority (brake > cancel > accel > coast > set/resume > throttle) into one action.
  always_comb begin
    act_s = ACT_DROP;
    if (brake) begin
      act_s = ACT_BRAKE;
    end else if (cancel) begin
      act_s = ACT_DROP;
    end else if (state_q == ST_MANUAL) begin
      // accel/coast have no meaning in MANUAL but still outrank set/resume.
      if (accel || coast) begin
        act_s = throttle ? ACT_RISE : ACT_DROP;
      end else if (set) begin
        act_s = (speed_q >= MIN_CRUISE) ? ACT_SET : (throttle ? ACT_RISE : ACT_DROP);
      end else if (resume && valid_q) begin
        act_s = ACT_RESUME;
      end else begin
        act_s = throttle ? ACT_RISE : ACT_DROP;
      end
    end else if (accel) begin
      act_s = ACT_ACCEL;
    end else if (coast && (state_q != ST_ACCEL)) begin
      // Leaving ACCEL always passes through CRUISE first.
      act_s = ACT_COAST;
    end else begin
      act_s = throttle ? ACT_OVERRIDE : ACT_TRACK;
    end
  end

  // Pick the ALU step and direction for the chosen action.
  always_comb begin
    alu_step_s = SPEED_ZERO;
    alu_sub_s  = 1'b0;
    case (act_s)
      ACT_BRAKE: begin
        alu_step_s = BRAKE_STEP;
        alu_sub_s  = 1'b1;
      end
      ACT_DROP, ACT_COAST: begin
        alu_step_s = SPEED_ONE;
        alu_sub_s  = 1'b1;
      end
      ACT_RISE, ACT_OVERRIDE, ACT_ACCEL: begin
        alu_step_s = SPEED_ONE;
        alu_sub_s  = 1'b0;
      end
      ACT_RESUME, ACT_TRACK: begin
        if (speed_q < cruise_q) begin
          alu_step_s = SPEED_ONE;
          alu_sub_s  = 1'b0;
        end else if (speed_q > cruise_q) begin
          alu_step_s = SPEED_ONE;
          alu_sub_s  = 1'b1;
        end else begin
          alu_step_s = SPEED_ZERO;
          alu_sub_s  = 1'b0;
        end
      end
      default: begin
        // ACT_SET: the captured target equals the current speed, so hold.
        alu_step_s = SPEED_ZERO;
        alu_sub_s  = 1'b0;
      end
    endcase
  end

  speed_alu u_alu (
    .operand_i (speed_q),
    .step_i    (alu_step_s),
    .sub_i     (alu_sub_s),
    .result_o  (alu_res_s),
    .flag_o    (alu_flag_s)
  );

  // Next state, target and target-valid flag from the action and the new speed.
  always_comb begin
    state_d  = state_q;
    cruise_d = cruise_q;
    valid_d  = valid_q;
    case (act_s)
      ACT_BRAKE, ACT_DROP, ACT_RISE: begin
        state_d = ST_MANUAL;
      end
      ACT_SET: begin
        state_d  = ST_CRUISE;
        cruise_d = speed_q;
        valid_d  = 1'b1;
      end
      ACT_RESUME, ACT_OVERRIDE, ACT_TRACK: begin
        state_d = ST_CRUISE;
      end
      ACT_ACCEL: begin
        state_d  = ST_ACCEL;
        cruise_d = alu_res_s;
      end
      ACT_COAST: begin
        cruise_d = alu_res_s;
        if (alu_flag_s || (alu_res_s < MIN_CRUISE)) begin
          state_d = ST_MANUAL;
          valid_d = 1'b0;
        end else begin
          state_d = ST_COAST;
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // State and output registers; reset clears everything including the stored target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_MANUAL;
      speed_q  <= SPEED_ZERO;
      cruise_q <= SPEED_ZERO;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= alu_res_s;
      cruise_q <= cruise_d;
      valid_q  <= valid_d;
      active_q <= (state_d != ST_MANUAL);
    end
  end

  assign speed         = speed_q;
  assign cruise_speed  = cruise_q;
  assign cruise_active = active_q;
  assign state         = state_q;

endmodule

// File: doc/cruise_speed_ctrl.md
CRUISE_SPEED_CTRL -- requirements
Module: cruise_speed_ctrl

Interface
REQ-001 Parameter MIN_CRUISE, default 8'd45, is the lowest speed at which cruise may engage or stay engaged.
REQ-002 Parameter BRAKE_STEP, default 8'd2, is the per-cycle speed decrement while brake is asserted.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 throttle  input  1  driver accelerator pedal.
REQ-006 brake  input  1  driver brake pedal.
REQ-007 set  input  1  engage cruise at current speed.
REQ-008 resume  input  1  re-engage the last stored cruise speed.
REQ-009 cancel  input  1  disengage cruise and keep the stored speed.
REQ-010 accel  input  1  raise cruise speed while held.
REQ-011 coast  input  1  lower cruise speed while held.
REQ-012 speed  output  8  current vehicle speed, registered.
REQ-013 cruise_speed  output  8  stored target speed, registered.
REQ-014 cruise_active  output  1  high in CRUISE, ACCEL or COAST, registered.
REQ-015 state  output  2  current FSM state code, for debug.

Function
REQ-016 States SHALL be MANUAL=0, CRUISE=1, ACCEL=2 and COAST=3, with one transition evaluated per cycle.
REQ-017 Input priority SHALL be brake > cancel > accel > coast > set/resume > throttle.
REQ-018 All speed arithmetic SHALL be unsigned 8-bit with saturation: an add carry-out forces 255 and a subtract borrow forces 0.
REQ-019 In MANUAL, speed SHALL be updated as follows: brake gives -BRAKE_STEP; else throttle gives +1; else -1 (coast-down), saturating at 0.
REQ-020 In MANUAL, set with speed >= MIN_CRUISE SHALL go to CRUISE next cycle, load cruise_speed with speed and set cruise_valid. If speed < MIN_CRUISE, set SHALL be ignored.
REQ-021 In MANUAL, resume with cruise_valid=1 SHALL go to CRUISE with cruise_speed unchanged. If cruise_valid=0, resume SHALL be ignored.
REQ-022 In CRUISE, speed SHALL move 1 per cycle toward cruise_speed: +1 if below, -1 if above, hold if equal.
REQ-023 In CRUISE, throttle SHALL override with +1 per cycle and leave cruise_speed unchanged. Speed returns to target once throttle is released.
REQ-024 CRUISE SHALL go to ACCEL on accel and to COAST on coast.
REQ-025 In ACCEL, speed SHALL increment by 1 per cycle and cruise_speed SHALL load the new speed each cycle. Deasserting accel SHALL return to CRUISE.
REQ-026 In COAST, speed SHALL decrement by 1 per cycle and cruise_speed SHALL track speed. Deasserting coast SHALL return to CRUISE. If the new speed < MIN_CRUISE, the FSM SHALL go to MANUAL and clear cruise_valid.
REQ-027 In any active state, brake SHALL go to MANUAL and apply -BRAKE_STEP in the same cycle; cruise_speed and cruise_valid are retained.
REQ-028 In any active state, cancel SHALL go to MANUAL with no brake decrement; that cycle applies the MANUAL coast-down of -1.
REQ-029 Simultaneous set and resume in MANUAL SHALL act as set.
REQ-030 Simultaneous accel and coast SHALL act as accel.
REQ-031 Outputs SHALL reflect the state and values registered at the previous edge. Input-to-output latency SHALL be 1 cycle and there are no combinational paths from inputs to outputs.
REQ-032 ACCEL saturation at 255 SHALL hold speed and cruise_speed at 255 without wrapping.

Reset
REQ-033 Asserting reset_n low SHALL immediately set speed=0, cruise_speed=0, cruise_valid=0, state=MANUAL and cruise_active=0, regardless of clk.
REQ-034 Reset asserted mid-ACCEL or mid-COAST SHALL discard the stored cruise speed. Operation resumes on the first rising clk edge after reset_n goes high.

Structure
REQ-035 The state encoding, MIN_CRUISE and BRAKE_STEP defaults, and the 8-bit speed width constant SHALL live in the shared package cruise_pkg.
REQ-036 All add/subtract SHALL go through one sub-module, speed_alu. It takes an 8-bit operand, an 8-bit step and a sub select, and returns a saturated 8-bit result plus a carry/borrow flag.
REQ-037 The FSM and the registers SHALL be in cruise_speed_ctrl. speed_alu is purely combinational.

Verification
REQ-038 Throttle held 50 cycles from reset, then set -> speed=50, cruise_speed=50, cruise_active=1 one cycle after set.
REQ-039 Speed 30, set -> ignored, state stays MANUAL, cruise_valid=0.
REQ-040 Cruising at 50, accel held 5 cycles -> speed=55, cruise_speed=55; after release speed holds 55.
REQ-041 Cruising at 60, brake 1 cycle -> speed=58, state MANUAL; resume -> CRUISE, speed climbs to 60 in 2 cycles.
REQ-042 Coast from cruise 46 for 2 cycles -> speed=44, state MANUAL, cruise_valid=0; later resume ignored.
REQ-043 Speed 254 in ACCEL for 3 cycles -> speed=255 and held. Then reset_n pulsed low asynchronously -> all outputs 0 before next clk edge.
